// File: rtl/uart_cmd_initiator.sv
// Host-side UART command initiator: sends a command code (and optional
// parameter) byte, then collects the response bytes and reports a status.
module uart_cmd_initiator #(
  parameter int TX_HOLD = 16,
  parameter int TX_GAP  = 10000,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  input  logic [7:0] cmd_param,
  output logic       cmd_ready,
  output logic [7:0] tx_in,
  output logic       tx_write,
  input  logic [7:0] rx_out,
  input  logic       rx_over,
  output logic       rsp_valid,
  output logic [1:0] rsp_status,
  output logic [7:0] rsp_data0,
  output logic [7:0] rsp_data1,
  output logic [7:0] rsp_data2,
  output logic       rx_stray
);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, GAP_CMD, SEND_PARAM, GAP_PARAM, WAIT_RSP, DONE
  } state_t;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_NAK     = 2'd1;
  localparam logic [1:0]  ST_TIMEOUT = 2'd2;
  localparam logic [23:0] HOLD_LAST  = 24'(TX_HOLD - 1);
  localparam logic [23:0] GAP_LAST   = 24'(TX_GAP - 1);
  localparam logic [23:0] TO_LAST    = 24'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  code_r, param_r;
  logic [23:0] cnt;
  logic [1:0]  idx;
  logic        rx_over_r;
  logic        rx_edge, last_byte, has_param;
  logic        hold_done, gap_done, to_done;
  logic [1:0]  rsp_n;

  function automatic logic [1:0] rsp_count(input logic [7:0] code);
    case (code)
      8'd2, 8'd3, 8'd6: return 2'd1;
      8'd4:             return 2'd3;
      default:          return 2'd0;
    endcase
  endfunction

  // Only single-byte replies carry an ACK/NAK; STATUS data is never judged.
  function automatic logic [1:0] rsp_decode(input logic [7:0] code, input logic [7:0] last);
    if ((code == 8'd2 || code == 8'd3 || code == 8'd6) && last != 8'h01)
      return ST_NAK;
    return ST_OK;
  endfunction

  assign rsp_n     = rsp_count(code_r);
  assign has_param = (code_r == 8'd5) || (code_r == 8'd6);
  assign rx_edge   = rx_over & ~rx_over_r;
  assign last_byte = rx_edge && ((idx + 2'd1) == rsp_n);
  assign hold_done = (cnt == HOLD_LAST);
  assign gap_done  = (cnt == GAP_LAST);
  assign to_done   = (cnt == TO_LAST);

  // NOTE: every register below uses non-blocking assignment so all flops
  // update together at the edge and reads see the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (cmd_valid) state_next = SEND_CMD;
      SEND_CMD:   if (hold_done) state_next = GAP_CMD;
      GAP_CMD:
        if (gap_done)
          state_next = has_param ? SEND_PARAM : (rsp_n != 2'd0 ? WAIT_RSP : DONE);
      SEND_PARAM: if (hold_done) state_next = GAP_PARAM;
      GAP_PARAM:  if (gap_done) state_next = (rsp_n != 2'd0) ? WAIT_RSP : DONE;
      WAIT_RSP:   if (last_byte || (!rx_edge && to_done)) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    tx_write  = (state == SEND_CMD) || (state == SEND_PARAM);
    rsp_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_r     <= '0;
      param_r    <= '0;
      cnt        <= '0;
      idx        <= '0;
      rx_over_r  <= 1'b0;
      rx_stray   <= 1'b0;
      tx_in      <= '0;
      rsp_status <= ST_OK;
      rsp_data0  <= '0;
      rsp_data1  <= '0;
      rsp_data2  <= '0;
    end else begin
      rx_over_r <= rx_over;
      rx_stray  <= rx_edge && (state != WAIT_RSP);
      case (state)
        IDLE:
          if (cmd_valid) begin
            code_r     <= cmd_code;
            param_r    <= cmd_param;
            tx_in      <= cmd_code;
            cnt        <= '0;
            idx        <= '0;
            rsp_status <= ST_OK;
            rsp_data0  <= '0;
            rsp_data1  <= '0;
            rsp_data2  <= '0;
          end
        SEND_CMD, SEND_PARAM: cnt <= hold_done ? '0 : cnt + 24'd1;
        GAP_CMD:
          if (gap_done) begin
            cnt <= '0;
            if (has_param) tx_in <= param_r;
          end else begin
            cnt <= cnt + 24'd1;
          end
        GAP_PARAM: cnt <= gap_done ? '0 : cnt + 24'd1;
        WAIT_RSP:
          // A byte arriving on the terminal count still wins over the timeout.
          if (rx_edge) begin
            case (idx)
              2'd0:    rsp_data0 <= rx_out;
              2'd1:    rsp_data1 <= rx_out;
              default: rsp_data2 <= rx_out;
            endcase
            idx <= idx + 2'd1;
            cnt <= '0;
            if (last_byte) rsp_status <= rsp_decode(code_r, rx_out);
          end else if (to_done) begin
            rsp_status <= ST_TIMEOUT;
          end else begin
            cnt <= cnt + 24'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator; a timeline model derived from the
// protocol rules is compared against the outputs every cycle.
module tb_uart_cmd_initiator;

  localparam int H = 4;
  localparam int G = 20;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code = 8'h00;
  logic [7:0] cmd_param = 8'h00;
  logic [7:0] rx_out = 8'h00;
  logic       rx_over = 1'b0;
  logic       cmd_ready, tx_write, rsp_valid, rx_stray;
  logic [7:0] tx_in, rsp_data0, rsp_data1, rsp_data2;
  logic [1:0] rsp_status;

  uart_cmd_initiator #(.TX_HOLD(H), .TX_GAP(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_param(cmd_param), .cmd_ready(cmd_ready), .tx_in(tx_in),
    .tx_write(tx_write), .rx_out(rx_out), .rx_over(rx_over),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data0(rsp_data0),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rx_stray(rx_stray)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the current command, as a timeline relative to the accept edge.
  bit         m_on = 1'b0;
  bit         m_hp = 1'b0;
  int         m_acc = 0;
  int         m_d = 0;
  int         m_nb = 0;
  logic [7:0] m_code = 8'h00;
  logic [7:0] m_param = 8'h00;
  logic [1:0] m_status = 2'd0;
  logic [7:0] m_data [3];
  logic [7:0] m_b [3];
  int         m_e [3];

  // Observation counters, written only by the compare process.
  int         valid_cnt = 0;
  int         last_valid = 0;
  int         stray_cnt = 0;
  int         txw_cnt = 0;
  int         tx_n = 0;
  logic       prev_txw = 1'b0;
  logic [7:0] tx_log [0:63];
  int         vb, sb, wb, tb_n;

  function automatic int rsp_n_of(input logic [7:0] c);
    if (c == 8'd2 || c == 8'd3 || c == 8'd6) return 1;
    if (c == 8'd4) return 3;
    return 0;
  endfunction

  always @(negedge clk) begin : cmp
    int t;
    if (rsp_valid) begin
      valid_cnt  <= valid_cnt + 1;
      last_valid <= cyc;
    end
    if (rx_stray) stray_cnt <= stray_cnt + 1;
    if (tx_write) txw_cnt <= txw_cnt + 1;
    if (tx_write && !prev_txw && tx_n < 64) begin
      tx_log[tx_n] <= tx_in;
      tx_n         <= tx_n + 1;
    end
    prev_txw <= tx_write;
    if (m_on) begin
      t = cyc - m_acc + 1;
      if (t >= 1) begin
        check("tx_write", tx_write, (t <= H) || (m_hp && t > H + G && t <= 2 * H + G));
        check("tx_in", tx_in, (m_hp && t > H + G) ? m_param : m_code);
        check("rsp_valid", rsp_valid, t == m_d);
        check("cmd_ready", cmd_ready, t > m_d);
        if (t >= m_d) begin
          check("rsp_status", rsp_status, m_status);
          check("rsp_data0", rsp_data0, m_data[0]);
          check("rsp_data1", rsp_data1, m_data[1]);
          check("rsp_data2", rsp_data2, m_data[2]);
        end
      end
    end
  end

  // Issues a command and records what the responder will send and when
  // (cycle numbers relative to the accept edge).
  task automatic start_cmd(input logic [7:0] code, input logic [7:0] param, input int nb,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int e0, input int e1, input int e2);
    int n, start, got;
    @(posedge clk); #1;
    m_on     = 1'b0;
    n        = rsp_n_of(code);
    m_hp     = (code == 8'd5) || (code == 8'd6);
    m_code   = code;
    m_param  = param;
    m_nb     = nb;
    m_b      = '{b0, b1, b2};
    m_e      = '{e0, e1, e2};
    m_data   = '{8'h00, 8'h00, 8'h00};
    m_status = 2'd0;
    start    = (m_hp ? 2 * (H + G) : H + G) + 1;
    if (n == 0) begin
      m_d = start;
    end else begin
      m_d = -1;
      got = 0;
      for (int i = 0; i < nb && m_d < 0; i++) begin
        if (m_e[i] > start + T - 1) break;
        m_data[i] = m_b[i];
        got++;
        start = m_e[i] + 1;
        if (got == n) begin
          m_d      = m_e[i] + 1;
          m_status = (code == 8'd4 || m_b[i] == 8'h01) ? 2'd0 : 2'd1;
        end
      end
      if (m_d < 0) begin
        m_d      = start + T;
        m_status = 2'd2;
      end
    end
    m_acc = cyc + 1;
    vb    = valid_cnt;
    sb    = stray_cnt;
    wb    = txw_cnt;
    tb_n  = tx_n;
    m_on  = 1'b1;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_param = param;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_now(input logic [7:0] b);
    rx_out  = b;
    rx_over = 1'b1;
    @(posedge clk); #1;
    rx_over = 1'b0;
  endtask

  task automatic rx_pulse_at(input int t, input logic [7:0] b);
    while (cyc < m_acc + t - 1) begin
      @(posedge clk); #1;
    end
    pulse_now(b);
  endtask

  task automatic ignore_at(input int t);
    while (cyc < m_acc + t - 1) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1;
    cmd_code  = 8'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input string tag);
    for (int i = 0; i < m_nb; i++) rx_pulse_at(m_e[i], m_b[i]);
    while (cyc < m_acc + m_d + 1) begin
      @(posedge clk); #1;
    end
    check({tag, "_valid_count"}, valid_cnt - vb, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tx_in", tx_in, 0);
    check("rst_tx_write", tx_write, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_data", {rsp_data0, rsp_data1, rsp_data2}, 0);
    check("rst_rx_stray", rx_stray, 0);
    repeat (5) @(posedge clk);
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_tx_write", tx_write, 0);

    // ON, ACK; a stray byte during the gap and an ignored request while busy.
    start_cmd(8'd2, 8'h00, 1, 8'h01, 8'h00, 8'h00, 30, 0, 0);
    rx_pulse_at(10, 8'hAA);
    ignore_at(15);
    respond("c2_ok");
    check("c2_valid_t", last_valid - m_acc + 1, 31);
    check("c2_status", rsp_status, 0);
    check("c2_data0", rsp_data0, 8'h01);
    check("c2_hold_cycles", txw_cnt - wb, 4);
    check("c2_tx_count", tx_n - tb_n, 1);
    check("c2_tx_byte0", tx_log[tb_n], 8'h02);
    check("c2_stray", stray_cnt - sb, 1);

    // ON, NAK.
    start_cmd(8'd2, 8'h00, 1, 8'h02, 8'h00, 8'h00, 26, 0, 0);
    respond("c2_nak");
    check("c2n_status", rsp_status, 1);
    check("c2n_data0", rsp_data0, 8'h02);
    check("c2n_valid_t", last_valid - m_acc + 1, 27);

    // STATUS with three response bytes.
    start_cmd(8'd4, 8'h00, 3, 8'h03, 8'h7F, 8'h01, 28, 40, 60);
    respond("c4");
    check("c4_data", {rsp_data0, rsp_data1, rsp_data2}, 24'h037F01);
    check("c4_status", rsp_status, 0);
    check("c4_valid_t", last_valid - m_acc + 1, 61);

    // OFF, reply lands on the timeout terminal count and must win.
    start_cmd(8'd3, 8'h00, 1, 8'h01, 8'h00, 8'h00, 124, 0, 0);
    respond("c3_edge");
    check("c3_status", rsp_status, 0);
    check("c3_valid_t", last_valid - m_acc + 1, 125);

    // LEVEL 0x40 with no reply: timeout 100 cycles after WAIT entry (49).
    start_cmd(8'd6, 8'h40, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    respond("c6_to");
    check("c6_status", rsp_status, 2);
    check("c6_valid_t", last_valid - m_acc + 1, 149);
    check("c6_hold_cycles", txw_cnt - wb, 8);
    check("c6_tx_count", tx_n - tb_n, 2);
    check("c6_tx_byte0", tx_log[tb_n], 8'h06);
    check("c6_tx_byte1", tx_log[tb_n + 1], 8'h40);

    // SILENCE 0x01: two bytes, no wait.
    start_cmd(8'd5, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    respond("c5");
    check("c5_status", rsp_status, 0);
    check("c5_valid_t", last_valid - m_acc + 1, 49);
    check("c5_tx_byte0", tx_log[tb_n], 8'h05);
    check("c5_tx_byte1", tx_log[tb_n + 1], 8'h01);

    // RESET: single byte, no response.
    start_cmd(8'd1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    respond("c1");
    check("c1_valid_t", last_valid - m_acc + 1, 25);
    check("c1_tx_byte0", tx_log[tb_n], 8'h01);

    // Reset in the middle of SEND_CMD.
    start_cmd(8'd2, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    m_on = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_tx_write", tx_write, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_tx_in", tx_in, 0);
    vb = valid_cnt;
    repeat (150) @(posedge clk);
    #1;
    check("mid_rst_no_valid", valid_cnt - vb, 0);
    start_cmd(8'd2, 8'h00, 1, 8'h01, 8'h00, 8'h00, 30, 0, 0);
    respond("post_rst");
    check("post_rst_status", rsp_status, 0);
    check("post_rst_valid_t", last_valid - m_acc + 1, 31);

    // Stray byte while idle.
    sb = stray_cnt;
    vb = valid_cnt;
    pulse_now(8'h55);
    repeat (3) @(posedge clk);
    #1;
    check("idle_stray", stray_cnt - sb, 1);
    check("idle_stray_no_valid", valid_cnt - vb, 0);
    check("idle_stray_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_initiator.md
# uart_cmd_initiator

Host-side command initiator for the receiver's UART command protocol: accepts one command (code plus optional parameter) from local logic, serialises it as bytes onto a UART transmitter, then collects the expected number of response bytes from a UART receiver and reports status and data. It sits opposite the receiver's command controller on the same serial link. It is used as the self-test and bring-up master on the host board.

## Interface
Parameters:
- TX_HOLD, 16: cycles `tx_write` is held high per byte.
- TX_GAP, 10000: idle cycles after each byte's hold before the next action.
- TIMEOUT, 1000000: max cycles between response bytes (24-bit counter, TIMEOUT ≤ 2^24−1).

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command request.
- `cmd_code`  in  8: command code, 1=RESET, 2=ON, 3=OFF, 4=STATUS, 5=SILENCE, 6=LEVEL.
- `cmd_param`  in  8: parameter byte, used only for codes 5 and 6.
- `cmd_ready`  out  1: high only in IDLE; the command is accepted on `cmd_valid & cmd_ready`.
- `tx_in`  out  8: byte to the UART transmitter.
- `tx_write`  out  1: transmit strobe; the UART latches on its rising edge.
- `rx_out`  in  8: byte from the UART receiver.
- `rx_over`  in  1: receive-done; a rising edge marks a new byte.
- `rsp_valid`  out  1: one-cycle pulse; result fields valid.
- `rsp_status`  out  2: 0=OK, 1=NAK, 2=TIMEOUT.
- `rsp_data0`, `rsp_data1`, `rsp_data2`  out  8 each: response bytes 0..2, zero when not received.
- `rx_stray`  out  1: one-cycle pulse on an `rx_over` rising edge outside WAIT_RSP.

## Operation
- Rising-edge detect: `rx_over_r` is registered from `rx_over`; `rx_edge = rx_over & ~rx_over_r`.
- Accept: latch code and param; clear `rsp_data*`, the byte index and the timeout counter; go to SEND_CMD.
- Expected response count N by code: 1→0, 2→1, 3→1, 4→3, 5→0, 6→1, any other→0.
- States:
  - IDLE: `cmd_ready=1`.
  - SEND_CMD: `tx_in=code`, `tx_write=1` for TX_HOLD cycles, then GAP_CMD.
  - GAP_CMD: `tx_write=0` for TX_GAP cycles. Next state is SEND_PARAM for codes 5/6; otherwise WAIT_RSP if N>0, else DONE.
  - SEND_PARAM and GAP_PARAM: same as SEND_CMD and GAP_CMD, using the parameter byte. Next state is WAIT_RSP if N>0, else DONE.
  - WAIT_RSP: each `rx_edge` stores `rx_out` into `rsp_data[idx]`, increments idx and clears the timeout counter. Go to DONE when idx reaches N. If the counter reaches TIMEOUT, go to DONE with TIMEOUT.
  - DONE: `rsp_valid=1` for one cycle, then IDLE.
- Status decode:
  - N=0: OK.
  - Codes 2, 3, 6: last byte 0x01 gives OK, any other value gives NAK.
  - Code 4: OK for any values.
  - Timeout overrides both.
- `tx_in` holds its value through the hold and gap periods. It changes only on entry to a SEND state.
- `rsp_data*` and `rsp_status` hold their values until the next accept.

## Timing
- Reset values: `cmd_ready=1` (the cycle after reset), `tx_in=0`, `tx_write=0`, `rsp_valid=0`, `rsp_status=0`, `rsp_data*=0`, `rx_stray=0`, `rx_over_r=0`; state is IDLE.
- Accept at edge A:
  - `tx_write` is high in cycles A+1 .. A+TX_HOLD and low from A+TX_HOLD+1.
  - The param byte, if any, starts at A+TX_HOLD+TX_GAP+1.
  - For N=0 with no param, `rsp_valid` is asserted in cycle A+TX_HOLD+TX_GAP+1.
- After the final response `rx_edge` at cycle E, `rsp_valid` is asserted at E+1 and `cmd_ready` at E+2.
- If `rx_edge` and the timeout terminal count occur in the same cycle, the byte wins and the counter clears.
- An `rx_edge` during SEND or GAP states: the byte is dropped and `rx_stray` pulses. The same applies in IDLE and DONE.
- `rst` mid-operation: on the next edge `tx_write=0` and the state returns to IDLE. A partially sent byte is abandoned and no `rsp_valid` is produced.
- `cmd_valid` while `cmd_ready=0` is ignored and not queued.

## Test plan
Benches use TX_HOLD=4, TX_GAP=20, TIMEOUT=100.
- Reset then idle: all outputs hold their reset values and `cmd_ready=1`.
- Code 2, responder returns 0x01 → `tx_in=0x02` with 4 high cycles on `tx_write`; `rsp_status=0`, `rsp_data0=0x01`. Repeat with 0x02 → `rsp_status=1`.
- Code 4, responder returns 0x03, 0x7F, 0x01 → `rsp_data0/1/2 = 0x03/0x7F/0x01`, `rsp_status=0`, one `rsp_valid`.
- Code 6, param 0x40, no response → bytes 0x06 then 0x40 are sent; `rsp_status=2` exactly 100 cycles after WAIT_RSP entry.
- Code 5, param 0x01 → two bytes are sent; `rsp_valid` with OK at A+2·(4+20)+1, with no wait.
- `rx_over` pulse while IDLE gives an `rx_stray` pulse. Assert `rst` during SEND_CMD: `tx_write` drops next cycle, no `rsp_valid`, and a new command is accepted normally afterwards.
